// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage valid/ready register pipeline with per-stage backpressure.
// Optional occupancy counter port 'occ' is built only when DFF_PIPE_OCC_EN is defined.
module dff_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [OCC_W-1:0] occ
`endif
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] r;
    logic             tail_full;

    // r[i] is low only when stage i and every stage after it is full and the
    // sink stalls; computing it from a running AND keeps the chain acyclic.
    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        tail_full = 1'b1;
        r         = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            tail_full = tail_full & v_q[i];
            r[i]      = !tail_full || out_ready;
        end
    end

    assign in_ready  = r[0] && !flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            v_q <= '0;
            // NOTE: the data array is reset too, so out_data reads 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            if (r[0]) begin
                v_q[0]    <= in_valid;
                data_q[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (r[i]) begin
                    v_q[i]    <= v_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

`ifdef DFF_PIPE_OCC_EN
    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occ_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign occ      = occ_q;

    always_ff @(posedge clk) begin
        if (!rstb || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
        end
    end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: DEPTH=4 scenarios plus a randomized DEPTH=1 scoreboard run.
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       rstb;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    logic       p1_in_valid;
    logic       p1_in_ready;
    logic [7:0] p1_in_data;
    logic       p1_out_valid;
    logic       p1_out_ready;
    logic [7:0] p1_out_data;

`ifdef DFF_PIPE_OCC_EN
    logic [2:0] occ;
    logic [0:0] p1_occ;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk       (clk),
        .rstb      (rstb),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1)) u_p1 (
        .clk       (clk),
        .rstb      (rstb),
        .flush     (1'b0),
        .in_valid  (p1_in_valid),
        .in_ready  (p1_in_ready),
        .in_data   (p1_in_data),
        .out_valid (p1_out_valid),
        .out_ready (p1_out_ready),
        .out_data  (p1_out_data)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occ       (p1_occ)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_occ(input string tag, input int exp);
`ifdef DFF_PIPE_OCC_EN
        check(tag, 32'(occ), 32'(exp));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check("send_in_ready", 32'(in_ready), 32'd1);
        tick();
    endtask

    initial begin
        logic [7:0] exp_head;
        logic [7:0] sb[$];
        logic       exp_rdy;
        logic       in_fire;
        logic       out_fire;

        rstb = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'hC3; out_ready = 1'b1;
        p1_in_valid = 1'b0; p1_in_data = 8'h00; p1_out_ready = 1'b0;
        tick(); tick();
        rstb = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_p1_out_valid", 32'(p1_out_valid), 32'd0);
        check_occ("rst_occ", 0);

        // Latency and throughput: 0x11 accepted on edge k, visible after edge k+3
        send(8'h11);
        send(8'h22);
        send(8'h33);
        in_valid = 1'b0;
        check("lat_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("lat_v0", 32'(out_valid), 32'd1);
        check("lat_d0", 32'(out_data), 32'h11);
        tick();
        check("lat_d1", 32'(out_data), 32'h22);
        tick();
        check("lat_d2", 32'(out_data), 32'h33);
        tick();
        check("lat_empty", 32'(out_valid), 32'd0);

        // Backpressure: fill four words, hold, then drain in order
        out_ready = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        in_valid = 1'b1; in_data = 8'h55;
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_data", 32'(out_data), 32'h11);
        check_occ("full_occ", 4);
        tick();
        check("hold_out_data", 32'(out_data), 32'h11);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check_occ("hold_occ", 4);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("drain_d1", 32'(out_data), 32'h22);
        check_occ("drain_occ3", 3);
        tick();
        check("drain_d2", 32'(out_data), 32'h33);
        check_occ("drain_occ2", 2);
        tick();
        check("drain_d3", 32'(out_data), 32'h44);
        check_occ("drain_occ1", 1);
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);
        check_occ("drain_occ0", 0);

        // Full-pipe streaming: one in and one out per edge for 20 words
        out_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        out_ready = 1'b1;
        exp_head = 8'h01;
        check("stream_head0", 32'(out_data), 32'(exp_head));
        for (int n = 0; n < 20; n++) begin
            send(8'(n + 5));
            exp_head++;
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(exp_head));
            check_occ("stream_occ", 4);
        end
        in_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            exp_head++;
            check("stream_tail", 32'(out_data), 32'(exp_head));
        end
        tick();
        check("stream_done", 32'(out_valid), 32'd0);

        // Flush with three held words and a simultaneous offer of 0xAA
        out_ready = 1'b0;
        send(8'h31); send(8'h32); send(8'h33);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check_occ("flush_occ", 0);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("flush_no_aa", 32'(out_valid), 32'd0);
        end

        // Reset dominates flush and input; first post-reset word flows normally
        out_ready = 1'b0;
        send(8'h41); send(8'h42); send(8'h43); send(8'h44);
        check("prereset_out_data", 32'(out_data), 32'h41);
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        rstb = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'h00);
        check_occ("midrst_occ", 0);
        rstb = 1'b1; flush = 1'b0; out_ready = 1'b1;
        send(8'h5A);
        in_valid = 1'b0;
        tick();
        check("postrst_k1", 32'(out_valid), 32'd0);
        tick();
        check("postrst_k2", 32'(out_valid), 32'd0);
        tick();
        check("postrst_valid", 32'(out_valid), 32'd1);
        check("postrst_data", 32'(out_data), 32'h5A);
        tick();
        check("postrst_empty", 32'(out_valid), 32'd0);

        // DEPTH=1 random traffic against a queue scoreboard
        for (int n = 0; n < 1000; n++) begin
            check("p1_out_valid", 32'(p1_out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("p1_out_data", 32'(p1_out_data), 32'(sb[0]));
            end
`ifdef DFF_PIPE_OCC_EN
            check("p1_occ", 32'(p1_occ), 32'(sb.size()));
`endif
            p1_in_valid  = ($urandom_range(3) != 0);
            p1_out_ready = ($urandom_range(2) != 0);
            p1_in_data   = 8'($urandom_range(255));
            #1;
            exp_rdy = (sb.size() == 0) || p1_out_ready;
            check("p1_in_ready", 32'(p1_in_ready), 32'(exp_rdy));
            in_fire  = p1_in_valid && exp_rdy;
            out_fire = (sb.size() != 0) && p1_out_ready;
            tick();
            if (out_fire) void'(sb.pop_front());
            if (in_fire) sb.push_back(p1_in_data);
        end
        check("p1_sb_bound", 32'(sb.size() <= 1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (legal: >= 1).
REQ-002 Parameter DEPTH, default 4, number of register stages (legal: >= 1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstb  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all held words, active-high.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  pipe accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream word.
REQ-009 out_valid  output  1  stage DEPTH-1 holds a word.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  word held in stage DEPTH-1.
REQ-012 occ  output  $clog2(DEPTH+1)  count of valid stages (present only with DFF_PIPE_OCC_EN, see REQ-030).

Function
REQ-013 Each stage i (0..DEPTH-1) SHALL hold a data register and a valid bit v[i].
REQ-014 Stage ready r[i] SHALL be !v[i] || r[i+1]; r[DEPTH] is out_ready.
REQ-015 in_ready SHALL be r[0] && !flush, combinational; no registered bubble.
REQ-016 Input transfer on edge when in_valid && in_ready; output transfer on edge when out_valid && out_ready.
REQ-017 On edge with r[i] high, stage i SHALL load from stage i-1 (stage 0 from in_data/in_valid), copying both data and valid.
REQ-018 On edge with r[i] low, stage i SHALL hold data and valid unchanged.
REQ-019 out_valid = v[DEPTH-1]; out_data = stage DEPTH-1 data; both registered outputs, no combinational input-to-output path.
REQ-020 Latency: word accepted on edge k into an empty pipe with out_ready high SHALL appear on out_data with out_valid at edge k+DEPTH-1.
REQ-021 Throughput: one word per cycle sustained while out_ready high and in_valid high.
REQ-022 Ordering: words SHALL leave in acceptance order; no loss, duplication or reordering.
REQ-023 Full (all v high) with out_ready low: in_ready low, all stages hold.
REQ-024 Full with out_ready high: simultaneous output and input transfer on same edge; occupancy unchanged.
REQ-025 Empty: out_valid low; out_data value unspecified except after reset.
REQ-026 flush high on edge: all v cleared; any input offered that cycle discarded; data registers need not change.
REQ-027 DEPTH=1: single register; in_ready = (!v[0] || out_ready) && !flush.

Reset
REQ-028 rstb low on edge: all v cleared, all data registers 0, occ 0; out_valid 0 and out_data 0 from the following cycle.
REQ-029 Reset SHALL dominate flush and any transfer; mid-stream reset discards all held words; first post-reset edge with rstb high accepts normally.

Configuration
REQ-030 Macro DFF_PIPE_OCC_EN defined: port occ present, registered, equals number of set v bits after each edge; +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither, 0 on flush or reset.
REQ-031 Macro DFF_PIPE_OCC_EN undefined: port occ and its logic absent; all other behaviour identical.

Verification
REQ-032 WIDTH=8, DEPTH=4, out_ready=1, send 0x11,0x22,0x33 on consecutive edges -> 0x11 out at edge k+3, then 0x22, 0x33 on consecutive edges, in_ready always 1.
REQ-033 Fill 4 words with out_ready=0 -> in_ready 0 after 4th accept, out_data 0x11 held stable; raise out_ready -> 4 words drain in order over 4 edges, occ 4,3,2,1,0.
REQ-034 Full pipe, in_valid=1, out_ready=1 -> one in and one out per edge, occ stays 4, sequence intact for 20 words.
REQ-035 Pipe holding 3 words, flush=1 with in_valid=1 in_data=0xAA -> next cycle out_valid 0, occ 0, 0xAA never emitted.
REQ-036 Pipe holding 2 words, rstb=0 together with flush=1 and in_valid=1 -> out_valid 0, out_data 0x00, occ 0; after rstb=1 send 0x5A -> 0x5A out 3 edges later.
REQ-037 DEPTH=1, random in_valid/out_ready for 1000 cycles against scoreboard -> no loss, duplication or reordering; out_data stable while out_valid && !out_ready.
